// File: rtl/cpu_nic.sv
// cpu_nic: single-entry network interface between a CPU register port and a router.
// One input buffer is filled by the router and drained by CPU loads from addr 00.
// One output buffer is filled by CPU stores to addr 10 and drained by the router.
// Optional build macro NIC_POLARITY_EN adds a net_polarity input. The output packet
// is then offered only when its bit 0 matches the router's virtual-channel phase.
module cpu_nic (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  addr_in,
    input  logic [63:0] d_in,
    input  logic        nicEn,
    input  logic        nicWrEn,
    output logic [63:0] d_out,
    input  logic [63:0] net_si,
    input  logic        net_si_valid,
    output logic        net_ri,
    output logic [63:0] net_so,
    output logic        net_so_valid,
    input  logic        net_ro
`ifdef NIC_POLARITY_EN
    ,
    input  logic        net_polarity
`endif
);

    logic [63:0] in_buf;
    logic        in_full;
    logic [63:0] out_buf;
    logic        out_full;

    logic        cpu_load;
    logic        cpu_store;
    logic        net_accept;
    logic        cpu_take;
    logic        out_accept;
    logic        out_drain;

    // Decode CPU and router handshakes from the pre-edge flags.
    always_comb begin
        cpu_load   = nicEn & ~nicWrEn;
        cpu_store  = nicEn & nicWrEn;
        net_accept = net_si_valid & net_ri;
        cpu_take   = cpu_load & (addr_in == 2'b00) & in_full;
        out_accept = cpu_store & (addr_in == 2'b10) & ~out_full;
        out_drain  = net_so_valid & net_ro;
    end

    // Router-facing outputs; net_ri is forced low while reset is asserted.
    always_comb begin
        net_ri = reset & ~in_full;
        net_so = out_buf;
`ifdef NIC_POLARITY_EN
        net_so_valid = out_full & (out_buf[0] == net_polarity);
`else
        net_so_valid = out_full;
`endif
    end

    // Input buffer: router fills it only when empty, a CPU load from 00 empties it.
    always_ff @(posedge clk) begin
        if (!reset) begin
            in_buf  <= 64'b0;
            in_full <= 1'b0;
        end else if (net_accept) begin
            in_buf  <= net_si;
            in_full <= 1'b1;
        end else if (cpu_take) begin
            in_full <= 1'b0;
        end
    end

    // Output buffer: a store is accepted only when empty before the edge, even if it drains then.
    always_ff @(posedge clk) begin
        if (!reset) begin
            out_buf  <= 64'b0;
            out_full <= 1'b0;
        end else if (out_accept) begin
            out_buf  <= d_in;
            out_full <= 1'b1;
        end else if (out_drain) begin
            out_full <= 1'b0;
        end
    end

    // Registered load data, zero in every cycle that does not follow a load.
    always_ff @(posedge clk) begin
        if (!reset) begin
            d_out <= 64'b0;
        end else if (cpu_load) begin
            case (addr_in)
                2'b00:   d_out <= in_buf;
                2'b01:   d_out <= {63'b0, in_full};
                2'b10:   d_out <= 64'b0;
                default: d_out <= {63'b0, out_full};
            endcase
        end else begin
            d_out <= 64'b0;
        end
    end

endmodule
